// File: rtl/spi_pkg.sv
// spi_pkg: shared constants, FSM encoding and read-word packing for the SPI
// 8-bit input receiver (spi_rx). Optional FIFO build macro: SPI_RX_FIFO_EN.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 8;

  // Bit positions inside the memory-mapped read word
  localparam int RD_DC    = 8;
  localparam int RD_VALID = 9;
  localparam int RD_FERR  = 10;
  localparam int RD_OVF   = 11;

  // CPU address the integrator decodes to produce rd
  localparam logic [31:0] SPI_RX_ADDR = 32'h0000_ff1c;

  typedef enum logic [0:0] {
    SPI_RX_IDLE = 1'b0,
    SPI_RX_RECV = 1'b1
  } spi_rx_state_e;

  // Build {20'h0, ovf, ferr, valid, dc, data}; payload reads zero when nothing is buffered.
  function automatic logic [31:0] spi_rx_word(input logic       ovf,
                                              input logic       ferr,
                                              input logic       valid,
                                              input logic [8:0] entry);
    logic [31:0] w;
    w           = 32'h0000_0000;
    w[RD_OVF]   = ovf;
    w[RD_FERR]  = ferr;
    w[RD_VALID] = valid;
    w[RD_DC:0]  = valid ? entry : 9'h000;
    return w;
  endfunction

endpackage

// File: rtl/spi_rx_if.sv
// spi_rx_if: board-side SPI pins plus the CPU read strobe / read word / irq.
// The receiver uses the slave modport, the driving side the master modport.
interface spi_rx_if;
  logic        cs_in;
  logic        sck_in;
  logic        sdi_in;
  logic        dc_in;
  logic        rd;
  logic [31:0] rdata;
  logic        irq;

  modport slave  (input cs_in, sck_in, sdi_in, dc_in, rd, output rdata, irq);
  modport master (output cs_in, sck_in, sdi_in, dc_in, rd, input rdata, irq);
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: DEPTH-entry circular buffer of 9-bit {dc, data} frames.
// Only present in the SPI_RX_FIFO_EN build. Pointers carry one extra wrap
// bit so full and empty are told apart. A push while full is accepted when
// a pop happens in the same cycle.
`ifdef SPI_RX_FIFO_EN
module spi_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_125mhz,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [8:0] din,
  output logic [8:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [8:0]  r_mem [DEPTH];
  logic        w_wr;
  logic        w_rd;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd  = pop & ~empty;
  assign w_wr  = push & (~full | w_rd);
  assign dout  = r_mem[r_rptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and pushes.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_wr) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_rd) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Frame storage, cleared on reset so the head never shows stale data.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 9'h000;
    end else if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= din;
    end
  end

endmodule
`endif

// File: rtl/spi_rx.sv
// spi_rx: SPI slave receiver. Synchronises the asynchronous cs/sck/sdi/dc
// pins, deserialises MSB-first 8-bit frames tagged with D/C, and buffers them
// for the CPU (read word at 32'hff1c, irq = data available).
// Build option SPI_RX_FIFO_EN: DEPTH-entry FIFO; otherwise one holding register.
module spi_rx
  import spi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic     clk_125mhz,
  input logic     reset,
  spi_rx_if.slave bus
);

  // DEPTH only matters for the FIFO build; the legal range is 2..16, power of two.
  if ((DEPTH < 2) || (DEPTH > 16)) begin : g_depth_out_of_range
  end

  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_sdi_s1, r_sdi_s2;
  logic r_dc_s1, r_dc_s2;

  spi_rx_state_e             r_state;
  logic [3:0]                r_bitcnt;
  logic [SPI_FRAME_BITS-1:0] r_shreg;
  logic                      r_dc_lat;
  logic                      r_ferr;
  logic                      r_ovf;

  logic       w_sck_rise;
  logic       w_cs_rise;
  logic       w_push;
  logic [8:0] w_frame;
  logic       w_pop;
  logic       w_empty;
  logic       w_full;
  logic       w_valid;
  logic [8:0] w_head;

  // Two-flop synchronisers on every pin, third stage on cs/sck for edge detection.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      r_cs_s1  <= 1'b1; r_cs_s2  <= 1'b1; r_cs_s3  <= 1'b1;
      r_sck_s1 <= 1'b1; r_sck_s2 <= 1'b1; r_sck_s3 <= 1'b1;
      r_sdi_s1 <= 1'b0; r_sdi_s2 <= 1'b0;
      r_dc_s1  <= 1'b0; r_dc_s2  <= 1'b0;
    end else begin
      r_cs_s1  <= bus.cs_in;  r_cs_s2  <= r_cs_s1;  r_cs_s3  <= r_cs_s2;
      r_sck_s1 <= bus.sck_in; r_sck_s2 <= r_sck_s1; r_sck_s3 <= r_sck_s2;
      r_sdi_s1 <= bus.sdi_in; r_sdi_s2 <= r_sdi_s1;
      r_dc_s1  <= bus.dc_in;  r_dc_s2  <= r_dc_s1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;

  // A frame is complete when cs rises after exactly eight sck rising edges.
  assign w_push  = (r_state == SPI_RX_RECV) & w_cs_rise & (r_bitcnt == 4'd8);
  assign w_frame = {r_dc_lat, r_shreg};

  // Receive FSM: shift bits on sck rises, close the frame on cs rise, flag short/long frames.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      r_state  <= SPI_RX_IDLE;
      r_bitcnt <= 4'd0;
      r_shreg  <= {SPI_FRAME_BITS{1'b0}};
      r_dc_lat <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      // A read clears the sticky error; a new error in the same cycle takes precedence below.
      if (bus.rd) r_ferr <= 1'b0;
      case (r_state)
        SPI_RX_IDLE: begin
          if (!r_cs_s2) begin
            r_bitcnt <= 4'd0;
            r_shreg  <= {SPI_FRAME_BITS{1'b0}};
            r_dc_lat <= 1'b0;
            r_state  <= SPI_RX_RECV;
          end
        end
        SPI_RX_RECV: begin
          if (w_cs_rise) begin
            r_state <= SPI_RX_IDLE;
            if (r_bitcnt != 4'd8) r_ferr <= 1'b1;
          end else if (w_sck_rise) begin
            r_shreg <= {r_shreg[SPI_FRAME_BITS-2:0], r_sdi_s2};
            if (r_bitcnt == 4'd0) r_dc_lat <= r_dc_s2;
            if (r_bitcnt != 4'd9) r_bitcnt <= r_bitcnt + 4'd1;
          end
        end
        default: r_state <= SPI_RX_IDLE;
      endcase
    end
  end

  assign w_valid = ~w_empty;
  assign w_pop   = bus.rd & w_valid;

`ifdef SPI_RX_FIFO_EN
  spi_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .push       (w_push),
    .pop        (w_pop),
    .din        (w_frame),
    .dout       (w_head),
    .empty      (w_empty),
    .full       (w_full)
  );
`else
  logic [8:0] r_hold;
  logic       r_hold_vld;

  assign w_head  = r_hold;
  assign w_empty = ~r_hold_vld;
  assign w_full  = r_hold_vld;

  // Single-entry holding register; a same-cycle read frees it for the incoming frame.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      r_hold     <= 9'h000;
      r_hold_vld <= 1'b0;
    end else if (w_push & (~r_hold_vld | w_pop)) begin
      r_hold     <= w_frame;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
`endif

  // Sticky overflow: a frame arrived with no room and no simultaneous read; a read clears it.
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_push & w_full & ~w_pop) begin
      r_ovf <= 1'b1;
    end else if (bus.rd) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.rdata = spi_rx_word(r_ovf, r_ferr, w_valid, w_head);
  assign bus.irq   = w_valid;

endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx: drives SPI frames into spi_rx and checks rdata/irq every cycle
// against a queue-based model of the receive buffer, plus literal checks
// taken from hand-worked frame examples. Handles both buffer builds.
`timescale 1ns/1ps
module tb_spi_rx;

  localparam int DEPTH = 8;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic clk_125mhz = 1'b0;
  logic reset;

  spi_rx_if bus ();

  spi_rx #(.DEPTH(DEPTH)) dut (
    .clk_125mhz (clk_125mhz),
    .reset      (reset),
    .bus        (bus)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  typedef struct {
    int         due;
    bit         good;
    logic [8:0] entry;
  } ev_t;

  ev_t        pend[$];
  logic [8:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_ferr = 1'b0;
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  bit         done_frames = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: buffer of frames with capacity CAP, sticky flags, one update per clock edge.
  task automatic model_step();
    bit  pop;
    bit  acc;
    bit  s_ovf;
    bit  s_ferr;
    ev_t ev;
    cyc++;
    if (reset) begin
      mq.delete();
      pend.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      pop    = bus.rd && (mq.size() > 0);
      acc    = 1'b0;
      s_ovf  = 1'b0;
      s_ferr = 1'b0;
      ev.entry = 9'h000;
      if ((pend.size() > 0) && (pend[0].due == cyc)) begin
        ev = pend.pop_front();
        if (!ev.good) s_ferr = 1'b1;
        else if ((mq.size() >= CAP) && !pop) s_ovf = 1'b1;
        else acc = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(ev.entry);
      m_ovf  = s_ovf  || (m_ovf  && !bus.rd);
      m_ferr = s_ferr || (m_ferr && !bus.rd);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w     = 32'h0;
    w[11] = m_ovf;
    w[10] = m_ferr;
    if (mq.size() > 0) begin
      w[9]   = 1'b1;
      w[8:0] = mq[0];
    end
    return w;
  endfunction

  initial forever begin
    @(posedge clk_125mhz);
    model_step();
  end

  // Per-cycle comparison of the DUT outputs against the model, away from the active edge.
  initial forever begin
    logic [31:0] exp;
    @(negedge clk_125mhz);
    if (!reset) begin
      exp = model_word();
      n_assert++;
      if ((bus.rdata !== exp) || (bus.irq !== exp[9])) begin
        n_fail++;
        $display("FAIL cycle_compare: cycle %0d got rdata=%h irq=%b expected rdata=%h irq=%b",
                 cyc, bus.rdata, bus.irq, exp, exp[9]);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_125mhz);
      #1;
    end
  endtask

  // Send nbits of val MSB-first; optionally reset after rst_after rises or read at the push edge.
  task automatic send_frame(input logic dc, input logic [15:0] val, input int nbits,
                            input int h, input int rst_after, input bit rd_at_push);
    int  counted;
    ev_t ev;
    counted    = 0;
    bus.dc_in  = dc;
    bus.cs_in  = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      bus.sck_in = 1'b0;
      bus.sdi_in = val[nbits-1-i];
      tick(h);
      bus.sck_in = 1'b1;
      tick(h);
      counted++;
      if (i + 1 == rst_after) begin
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        counted = 0;
      end
    end
    tick(3);
    bus.cs_in = 1'b1;
    ev.due    = cyc + 3;
    ev.good   = (counted == 8);
    ev.entry  = {dc, val[7:0]};
    pend.push_back(ev);
    if (rd_at_push) begin
      tick(2);
      bus.rd = 1'b1;
      tick(1);
      bus.rd = 1'b0;
    end else begin
      tick(3);
    end
  endtask

  task automatic read_expect(input string name, input logic [31:0] exp);
    bus.rd = 1'b1;
    chk(name, bus.rdata, exp);
    tick(1);
    bus.rd = 1'b0;
  endtask

  initial begin
    bus.cs_in  = 1'b1;
    bus.sck_in = 1'b1;
    bus.sdi_in = 1'b0;
    bus.dc_in  = 1'b0;
    bus.rd     = 1'b0;
    reset      = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(2);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_irq", {31'h0, bus.irq}, 32'h0);

    // dc=1, 8'hA5 at the transmitter's 400 ns half-period
    send_frame(1'b1, 16'h00A5, 8, 50, 0, 1'b0);
    chk("a5_rdata", bus.rdata, 32'h0000_03A5);
    chk("a5_irq", {31'h0, bus.irq}, 32'h1);
    read_expect("a5_read", 32'h0000_03A5);
    chk("a5_after_rd", bus.rdata, 32'h0);
    chk("a5_after_irq", {31'h0, bus.irq}, 32'h0);

    // Back-to-back frames; the first is read while the second is still shifting in
    send_frame(1'b0, 16'h003C, 8, 4, 0, 1'b0);
    fork
      send_frame(1'b1, 16'h00C3, 8, 4, 0, 1'b0);
      begin
        tick(10);
        read_expect("b2b_first", 32'h0000_023C);
      end
    join
    read_expect("b2b_second", 32'h0000_03C3);
    chk("b2b_empty", bus.rdata, 32'h0);

    // Short (7) and long (9) frames are discarded with a frame error
    send_frame(1'b0, 16'h0055, 7, 4, 0, 1'b0);
    send_frame(1'b1, 16'h01AA, 9, 4, 0, 1'b0);
    chk("ferr_flag", bus.rdata, 32'h0000_0400);
    read_expect("ferr_read", 32'h0000_0400);
    chk("ferr_cleared", bus.rdata, 32'h0);

    // Overflow: frames 0..8 without reads; only the first CAP are kept
    for (int i = 0; i < 9; i++) send_frame(1'b0, 16'(i), 8, 3, 0, 1'b0);
    for (int i = 0; i < CAP; i++)
      read_expect("ovf_read", 32'h200 | 32'(i) | ((i == 0) ? 32'h800 : 32'h0));
    chk("ovf_drained", bus.rdata, 32'h0);

    // Full buffer with a read landing on the same edge as the next push
    for (int i = 0; i < CAP; i++) send_frame(1'b1, 16'(16'h10 + i), 8, 3, 0, 1'b0);
    send_frame(1'b0, 16'h005A, 8, 3, 0, 1'b1);
    chk("fullpop_ovf", {31'h0, bus.rdata[11]}, 32'h0);
    chk("fullpop_irq", {31'h0, bus.irq}, 32'h1);
    for (int i = 1; i < CAP; i++) read_expect("fullpop_drain", 32'h300 | (32'h10 + 32'(i)));
    read_expect("fullpop_new", 32'h0000_025A);
    chk("fullpop_empty", bus.rdata, 32'h0);

    // Reset after four sck rises, then finish the frame
    send_frame(1'b0, 16'h00F0, 8, 5, 4, 1'b0);
    chk("rst_ferr", bus.rdata, 32'h0000_0400);
    chk("rst_irq", {31'h0, bus.irq}, 32'h0);
    send_frame(1'b0, 16'h0081, 8, 5, 0, 1'b0);
    read_expect("rst_next", 32'h0000_0681);
    read_expect("rst_second", 32'h0);

    // Randomised frames with independent random read strobes
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int r;
          int nb;
          r  = $urandom_range(0, 9);
          nb = (r == 0) ? 7 : ((r == 1) ? 9 : 8);
          send_frame(1'($urandom_range(0, 1)), 16'($urandom), nb,
                     $urandom_range(3, 10), 0, 1'b0);
        end
        done_frames = 1'b1;
      end
      begin
        while (!done_frames) begin
          tick($urandom_range(1, 40));
          bus.rd = 1'b1;
          tick(1);
          bus.rd = 1'b0;
        end
      end
    join
    repeat (CAP + 1) begin
      bus.rd = 1'b1;
      tick(1);
      bus.rd = 1'b0;
      tick(1);
    end
    chk("final_empty", bus.rdata, 32'h0);
    chk("final_irq", {31'h0, bus.irq}, 32'h0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
